// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } lcd_state_e;

    localparam int unsigned LCD_ON_BIT = 31;
    localparam int unsigned LCD_EN_BIT = 10;
    localparam int unsigned LCD_RS_BIT = 9;
    localparam int unsigned LCD_RW_BIT = 8;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    // Power-on sequence: 8-bit/2-line, display on, clear, entry mode increment.
    localparam int unsigned INIT_LEN = 4;
    localparam logic [INIT_LEN-1:0][7:0] INIT_SEQ = {8'h06, CMD_CLEAR, 8'h0C, 8'h38};

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_req_t;

    // Clear and return-home need the long execution wait.
    function automatic logic is_long_cmd(input lcd_req_t req);
        return !req.rs && (req.data == CMD_CLEAR || req.data == CMD_HOME ||
                           req.data == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_req_fifo.sv
// Synchronous request queue with wrapping pointers and an occupancy count.
module lcd_req_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_push,
    input  lcd_req_t                   i_din,
    input  logic                       i_pop,
    output lcd_req_t                   o_head_c,
    output logic                       o_full_c,
    output logic                       o_empty_c,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    lcd_req_t          r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_pop_ok;
    logic              w_push_ok;

    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_head_c  = r_mem[r_rptr];
    assign o_count   = r_count;

    // A pop frees a slot in the same cycle, so push-while-full is accepted then.
    assign w_pop_ok  = i_pop && !o_empty_c;
    assign w_push_ok = i_push && (!o_full_c || w_pop_ok);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write controller: queues EN-edge requests and replays them with pin timing.
// Optional LCD_INIT_EN issues a built-in power-on sequence before serving the queue.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned T_SETUP_CYC = 2,
    parameter int unsigned T_EN_CYC    = 12,
    parameter int unsigned T_HOLD_CYC  = 2,
    parameter int unsigned T_EXEC_CYC  = 1850,
    parameter int unsigned T_CLR_CYC   = 76000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_lcd_word,
    input  logic        i_ovf_clr,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_overflow
);

    localparam int unsigned TW = $clog2(T_CLR_CYC + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic            r_en_q;
    logic            r_push;
    lcd_req_t        r_push_req;
    logic            r_lcd_on;
    logic            r_overflow;

    lcd_state_e      r_state;
    lcd_state_e      w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic [7:0]      r_lcd_data;
    logic [7:0]      w_data_nxt;
    logic            r_lcd_rs;
    logic            w_rs_nxt;
    logic            r_lcd_en;
    logic            w_en_nxt;

    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    lcd_req_t        w_head;
    logic [CW-1:0]   w_count;
    logic            w_drop;
    logic            w_init_busy;
    lcd_req_t        w_init_req;
    lcd_req_t        w_cur;
    logic            w_unused;

    assign w_unused = ^{i_lcd_word[30:11], i_lcd_word[LCD_RW_BIT]};

    // Registered edge detect; RW is ignored because the controller only writes.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_en_q     <= 1'b0;
            r_push     <= 1'b0;
            r_push_req <= '0;
            r_lcd_on   <= 1'b0;
        end else begin
            r_en_q     <= i_lcd_word[LCD_EN_BIT];
            r_push     <= i_lcd_word[LCD_EN_BIT] && !r_en_q;
            r_push_req <= '{rs: i_lcd_word[LCD_RS_BIT], data: i_lcd_word[7:0]};
            r_lcd_on   <= i_lcd_word[LCD_ON_BIT];
        end
    end

    lcd_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_push    (r_push),
        .i_din     (r_push_req),
        .i_pop     (w_pop),
        .o_head_c  (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_count   (w_count)
    );

    assign w_drop = r_push && w_full && !w_pop;

    // Sticky overflow; a new drop outranks a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)        r_overflow <= 1'b0;
        else if (w_drop)    r_overflow <= 1'b1;
        else if (i_ovf_clr) r_overflow <= 1'b0;
    end

`ifdef LCD_INIT_EN
    localparam int unsigned IW = $clog2(INIT_LEN + 1);

    logic [IW-1:0] r_init_cnt;

    assign w_init_busy = (r_init_cnt != IW'(INIT_LEN));
    assign w_init_req  = '{rs: 1'b0, data: INIT_SEQ[r_init_cnt[IW-2:0]]};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)                                r_init_cnt <= '0;
        else if (r_state == ST_IDLE && w_init_busy) r_init_cnt <= r_init_cnt + IW'(1);
    end
`else
    assign w_init_busy = 1'b0;
    assign w_init_req  = '0;
`endif

    assign w_cur = '{rs: r_lcd_rs, data: r_lcd_data};

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_lcd_data <= '0;
            r_lcd_rs   <= 1'b0;
            r_lcd_en   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_lcd_data <= w_data_nxt;
            r_lcd_rs   <= w_rs_nxt;
            r_lcd_en   <= w_en_nxt;
        end
    end

    // Each phase loads its length minus one and leaves when the timer reaches zero.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_data_nxt  = r_lcd_data;
        w_rs_nxt    = r_lcd_rs;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_init_busy) begin
                    w_data_nxt  = w_init_req.data;
                    w_rs_nxt    = w_init_req.rs;
                    w_timer_nxt = TW'(T_SETUP_CYC - 1);
                    w_state_nxt = ST_SETUP;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_data_nxt  = w_head.data;
                    w_rs_nxt    = w_head.rs;
                    w_timer_nxt = TW'(T_SETUP_CYC - 1);
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_timer == '0) begin
                    w_timer_nxt = TW'(T_EN_CYC - 1);
                    w_state_nxt = ST_PULSE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            ST_PULSE: begin
                if (r_timer == '0) begin
                    w_timer_nxt = TW'(T_HOLD_CYC - 1);
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            ST_HOLD: begin
                if (r_timer == '0) begin
                    w_timer_nxt = is_long_cmd(w_cur) ? TW'(T_CLR_CYC - 1) : TW'(T_EXEC_CYC - 1);
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            ST_EXEC: begin
                if (r_timer == '0) w_state_nxt = ST_IDLE;
                else               w_timer_nxt = r_timer - TW'(1);
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_en_nxt = (w_state_nxt == ST_PULSE);
    end

    assign o_lcd_data = r_lcd_data;
    assign o_lcd_rs   = r_lcd_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = r_lcd_en;
    assign o_lcd_on   = r_lcd_on;
    assign o_overflow = r_overflow;
    assign o_busy     = (w_count != '0) || (r_state != ST_IDLE) || w_init_busy;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters; LCD_INIT_EN selects the init test.
module tb_lcd_ctrl;

    localparam int unsigned T_SETUP = 2;
    localparam int unsigned T_EN    = 3;
    localparam int unsigned T_HOLD  = 2;
    localparam int unsigned T_EXEC  = 10;
    localparam int unsigned T_CLR   = 40;
    localparam int unsigned DEPTH   = 4;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [31:0] word    = '0;
    logic        ovf_clr = 1'b0;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_en;
    logic        o_lcd_on;
    logic        o_busy;
    logic        o_overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] mon_q [$];
    int         mon_t [$];
    int         cyc     = 0;
    logic       en_prev = 1'b0;

    lcd_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .T_SETUP_CYC (T_SETUP),
        .T_EN_CYC    (T_EN),
        .T_HOLD_CYC  (T_HOLD),
        .T_EXEC_CYC  (T_EXEC),
        .T_CLR_CYC   (T_CLR)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rst_n),
        .i_lcd_word (word),
        .i_ovf_clr  (ovf_clr),
        .o_lcd_data (o_lcd_data),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_on   (o_lcd_on),
        .o_busy     (o_busy),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    // Record {rs,data} and cycle of every EN rise seen on the pins.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (o_lcd_en && !en_prev) begin
            mon_q.push_back({o_lcd_rs, o_lcd_data});
            mon_t.push_back(cyc);
        end
        en_prev = o_lcd_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic lcd_write(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        word = {1'b1, 20'd0, 1'b1, rs, rw, d};
        @(negedge clk);
        word[10] = 1'b0;
    endtask

    task automatic wait_en(input logic lvl, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_lcd_en !== lvl && n < max);
    endtask

    task automatic wait_data(input logic [7:0] v, input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_lcd_data !== v && n < max);
    endtask

    task automatic wait_busy_low(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_busy !== 1'b0 && n < max);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        wait_busy_low(max, n);
        check(tag, 32'(o_busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Command followed by data 0x42: EN fall to 0x42 setup = HOLD + EXEC/CLR + 1 IDLE.
    logic [8:0] cmd_tab [5] = '{9'h001, 9'h038, 9'h101, 9'h003, 9'h002};
    int         gap_tab [5] = '{43, 13, 13, 43, 43};

    initial begin
        int n;
        int bad;

`ifdef LCD_INIT_EN
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lcd_write(1'b1, 1'b0, 8'h77);
        check("init_busy", 32'(o_busy), 32'd1);
        wait_idle("init_idle", 1000);
        check("init_count", 32'(mon_q.size()), 32'd5);
        if (mon_q.size() == 5) begin
            check("init_0", 32'(mon_q[0]), 32'h038);
            check("init_1", 32'(mon_q[1]), 32'h00C);
            check("init_2", 32'(mon_q[2]), 32'h001);
            check("init_3", 32'(mon_q[3]), 32'h006);
            check("init_user", 32'(mon_q[4]), 32'h177);
            check("init_gap_38", 32'(mon_t[1] - mon_t[0]), 32'd18);
            check("init_gap_clr", 32'(mon_t[3] - mon_t[2]), 32'd48);
            check("init_gap_06", 32'(mon_t[4] - mon_t[3]), 32'd18);
        end
`else
        // Reset held, then quiet idle after release.
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en,
                                    o_lcd_on, o_busy, o_overflow}), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if ({o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_overflow} != 0)
                bad++;
        end
        check("quiet_after_reset", 32'(bad), 32'd0);

        // Single write: strobe drive to EN rise is 5 cycles, one already spent dropping EN.
        lcd_write(1'b1, 1'b0, 8'h41);
        wait_en(1'b1, 50, n);
        check("single_en_latency", 32'(n), 32'd4);
        check("single_data", 32'(o_lcd_data), 32'h41);
        check("single_rs", 32'(o_lcd_rs), 32'd1);
        check("single_on", 32'(o_lcd_on), 32'd1);
        wait_en(1'b0, 50, n);
        check("single_en_width", 32'(n), 32'(T_EN));
        wait_busy_low(100, n);
        check("single_busy_tail", 32'(n), 32'(T_HOLD + T_EXEC));
        check("single_data_kept", 32'(o_lcd_data), 32'h41);

        // Long vs short execution waits.
        for (int i = 0; i < 5; i++) begin
            lcd_write(cmd_tab[i][8], 1'b0, cmd_tab[i][7:0]);
            lcd_write(1'b1, 1'b0, 8'h42);
            wait_en(1'b1, 50, n);
            check($sformatf("cmd_%0h_data", cmd_tab[i]), 32'({o_lcd_rs, o_lcd_data}),
                  32'(cmd_tab[i]));
            wait_en(1'b0, 50, n);
            wait_data(8'h42, 200, n);
            check($sformatf("cmd_%0h_gap", cmd_tab[i]), 32'(n), 32'(gap_tab[i]));
            wait_idle("cmd_idle", 200);
        end

        // Six strobes: one popped at once, four queued, last dropped.
        mon_q.delete();
        mon_t.delete();
        for (int i = 0; i < 6; i++) lcd_write(1'b1, 1'b0, 8'(8'h10 + i));
        @(negedge clk);
        check("ovf_set", 32'(o_overflow), 32'd1);
        wait_idle("ovf_idle", 500);
        check("ovf_count", 32'(mon_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < mon_q.size())
                check($sformatf("ovf_order_%0d", i), 32'(mon_q[i]), 32'(9'h110 + i));
        check("ovf_sticky", 32'(o_overflow), 32'd1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(o_overflow), 32'd0);

        // EN held high with RW=1: one transfer, RW pin stays low.
        mon_q.delete();
        mon_t.delete();
        @(negedge clk);
        word = 32'h8000_0755;
        repeat (100) @(negedge clk);
        check("held_rw_pin", 32'(o_lcd_rw), 32'd0);
        word = 32'h8000_0355;
        wait_idle("held_idle", 200);
        check("held_count", 32'(mon_q.size()), 32'd1);
        if (mon_q.size() > 0) check("held_data", 32'(mon_q[0]), 32'h155);

        // ON bit follows with one cycle of delay.
        @(negedge clk);
        word = 32'h0;
        @(negedge clk);
        check("on_follow", 32'(o_lcd_on), 32'd0);

        // Reset mid-PULSE with two entries queued.
        for (int i = 0; i < 3; i++) lcd_write(1'b1, 1'b0, 8'(8'h61 + i));
        wait_en(1'b1, 50, n);
        check("rst_pulse_reached", 32'(o_lcd_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_en_async", 32'(o_lcd_en), 32'd0);
        check("rst_busy_async", 32'(o_busy), 32'd0);
        check("rst_data_async", 32'({o_lcd_rs, o_lcd_data}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_q.delete();
        mon_t.delete();
        repeat (100) @(negedge clk);
        check("rst_flushed", 32'(mon_q.size()), 32'd0);
        check("rst_idle", 32'(o_busy), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
